// File: rtl/usb_tx_bit_timer.sv
// USB transmit bit timer: mid-bit shift strobe, stall-aware bit counting
// and a registered one-cycle completion pulse for each packet field.
module usb_tx_bit_timer #(
    parameter int CLKS_PER_BIT = 8,
    parameter int SHIFT_PHASE  = 4,
    parameter int MAX_BITS     = 64,
    localparam int CNT_W       = $clog2(MAX_BITS + 1)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             d_edge,
    input  logic             start,
    input  logic [CNT_W-1:0] field_bits,
    input  logic             stall,
    input  logic             abort,
    output logic             busy,
    output logic             shift_enable,
    output logic [CNT_W-1:0] bit_count,
    output logic             field_done,
    output logic             config_err
);

    localparam int PH_W = $clog2(CLKS_PER_BIT + 1);

    localparam logic [PH_W-1:0]  PH_ONE   = PH_W'(1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CLKS_PER_BIT);
    localparam logic [PH_W-1:0]  PH_SHIFT = PH_W'(SHIFT_PHASE);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BITS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    logic             state;
    logic [PH_W-1:0]  phase;
    logic [CNT_W-1:0] field_len;
    logic [CNT_W-1:0] next_count;

    logic start_idle;
    logic legal_len;
    logic accept;
    logic strobe;
    logic count_en;
    logic last_bit;

    // Start qualification, strobe and terminal-count decode.
    always_comb begin
        start_idle = (state == ST_IDLE) && start && !abort;
        legal_len  = (field_bits != '0) && (field_bits <= CNT_MAX);
        accept     = start_idle && legal_len;
        strobe     = (state == ST_RUN) && (phase == PH_SHIFT);
        count_en   = strobe && !stall && !abort;
        next_count = bit_count + CNT_ONE;
        last_bit   = count_en && (next_count == field_len);
    end

    // Two-state control: abort wins, last counted bit ends the field.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= ST_IDLE;
        end else if (abort) begin
            state <= ST_IDLE;
        end else if (state == ST_IDLE) begin
            if (accept) state <= ST_RUN;
        end else if (last_bit) begin
            state <= ST_IDLE;
        end
    end

    // Bit phase: parked at 1 outside RUN, resynced by line edges.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            phase <= PH_ONE;
        end else if (state != ST_RUN || abort || last_bit) begin
            phase <= PH_ONE;
        end else if (d_edge || phase == PH_LAST) begin
            phase <= PH_ONE;
        end else begin
            phase <= phase + PH_ONE;
        end
    end

    // Field length captured once per accepted start.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            field_len <= '0;
        end else if (accept) begin
            field_len <= field_bits;
        end
    end

    // Counted bits; stuffed bits shift out but are not counted.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bit_count <= '0;
        end else if (abort || accept) begin
            bit_count <= '0;
        end else if (count_en) begin
            bit_count <= next_count;
        end
    end

    // Registered one-cycle status pulses.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            field_done <= 1'b0;
            config_err <= 1'b0;
        end else begin
            field_done <= last_bit;
            config_err <= start_idle && !legal_len;
        end
    end

    assign busy         = (state == ST_RUN);
    assign shift_enable = strobe;

endmodule
